// File: rtl/freq_meter_pkg.sv
// Shared types and default sizing for the gated frequency meter.
// Optional overflow reporting is enabled by defining FREQ_METER_OVF_EN.
package freq_meter_pkg;

  localparam int unsigned GATE_CYCLES_DEF = 50_000_000;
  localparam int unsigned GW_DEF          = 26;
  localparam int unsigned CW_DEF          = 26;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/freq_meter_if.sv
// Request/result bundle between a frequency meter and its controller.
// The overflow signal exists only when FREQ_METER_OVF_EN is defined.
interface freq_meter_if #(
  parameter int unsigned CW = freq_meter_pkg::CW_DEF
);
  logic          start;
  logic          busy;
  logic [CW-1:0] count_out;
  logic          count_valid;
`ifdef FREQ_METER_OVF_EN
  logic          overflow;

  modport master (output start, input busy, count_out, count_valid, overflow);
  modport slave  (input start, output busy, count_out, count_valid, overflow);
`else
  modport master (output start, input busy, count_out, count_valid);
  modport slave  (input start, output busy, count_out, count_valid);
`endif
endinterface

// File: rtl/freq_meter_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge
// detector; rise is high for one clk cycle per synchronized 0->1 transition.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d_async;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a GATE_CYCLES clk window per start request.
// Defining FREQ_METER_OVF_EN adds an overflow flag for a saturated edge count.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int unsigned GW          = GW_DEF,
  parameter int unsigned CW          = CW_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sig_in,
  freq_meter_if.slave  bus
);

  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] EDGE_MAX  = '1;

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] gate_cnt;
  logic [CW-1:0] edge_cnt;
  logic [CW-1:0] edge_nxt_c;
  logic          rise;
  logic          gate_end_c;
  logic          clear_c;
  logic          count_c;
  logic          load_c;

  sync_edge_det u_sync (
    .clk     (clk),
    .reset   (reset),
    .d_async (sig_in),
    .rise    (rise)
  );

  assign gate_end_c = (gate_cnt == GATE_LAST);
  // Saturating increment; also used to load the final count so a rise in the last gate cycle is included.
  assign edge_nxt_c = (rise && (edge_cnt != EDGE_MAX)) ? edge_cnt + CW'(1) : edge_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = MEASURE;
      MEASURE: if (gate_end_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clear_c = 1'b0;
    count_c = 1'b0;
    load_c  = 1'b0;
    case (state)
      IDLE: clear_c = bus.start;
      MEASURE: begin
        count_c = 1'b1;
        load_c  = gate_end_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else if (clear_c) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else if (count_c) begin
      gate_cnt <= gate_cnt + GW'(1);
      edge_cnt <= edge_nxt_c;
    end
  end

  // Results are loaded on the last gate cycle so they appear alongside count_valid in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.busy        <= 1'b0;
      bus.count_valid <= 1'b0;
      bus.count_out   <= '0;
    end else begin
      bus.busy        <= (state_nxt != IDLE);
      bus.count_valid <= load_c;
      if (load_c) bus.count_out <= edge_nxt_c;
    end
  end

`ifdef FREQ_METER_OVF_EN
  logic sat;
  logic sat_nxt_c;

  // Overflow means at least one rise arrived while the count was already pinned at its maximum.
  assign sat_nxt_c = sat | (rise & (edge_cnt == EDGE_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat          <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      if (clear_c)      sat <= 1'b0;
      else if (count_c) sat <= sat_nxt_c;
      if (load_c) bus.overflow <= sat_nxt_c;
    end
  end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: two instances (12-bit and 6-bit counts)
// measure the same sig_in; results are checked against an edge-history model.
module tb_freq_meter;

  localparam int unsigned GATE = 1000;
  localparam int unsigned CW_A = 12;
  localparam int unsigned CW_B = 6;
  localparam int          MAX_B = (1 << CW_B) - 1;

  logic clk = 1'b0;
  logic reset;
  logic sig_in;

  freq_meter_if #(.CW(CW_A)) bus_a ();
  freq_meter_if #(.CW(CW_B)) bus_b ();

  freq_meter #(.GATE_CYCLES(GATE), .GW(10), .CW(CW_A)) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .bus(bus_a));

  freq_meter #(.GATE_CYCLES(GATE), .GW(10), .CW(CW_B)) dut_b (
    .clk(clk), .reset(reset), .sig_in(sig_in), .bus(bus_b));

  initial forever #5 clk = ~clk;

  int          cyc = 0;
  int unsigned div_cnt = 0;
  int          sig_mode = 0;
  int          div_sh = 3;
  int          rand_pct = 50;
  bit          hist [0:65535];
  int          vectors = 0;
  int          miscompares = 0;

  initial forever @(posedge clk) cyc++;

  // sig_in changes on the falling edge; hist[c] is the value seen by the rising edge ending cycle c.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      div_cnt++;
      case (sig_mode)
        0:       sig_in = 1'b0;
        1:       sig_in = 1'b1;
        2:       sig_in = div_cnt[div_sh-1];
        default: sig_in = ($urandom_range(99) < rand_pct);
      endcase
      if (cyc < 65536) hist[cyc] = sig_in;
    end
  end

  // Expected count for start driven in cycle s: 0->1 transitions of sig_in, delayed two cycles by
  // the synchronizer, that land inside the GATE-cycle window beginning in cycle s+1.
  function automatic int model_edges(input int s);
    int n = 0;
    for (int j = s - 1; j <= s + int'(GATE) - 2; j++)
      if (!hist[j-1] && hist[j]) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    bus_a.start = v;
    bus_b.start = v;
  endtask

  // Waits n cycles, then confirms both meters are idle and silent throughout.
  task automatic idle(input string name, input int n);
    int strobes = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus_a.count_valid || bus_b.count_valid) strobes++;
    end
    check({name, ":idle_strobes"}, 64'(strobes), 64'd0);
    check({name, ":idle_busy"}, 64'(bus_a.busy), 64'd0);
  endtask

  // Called on a falling edge; drives start this cycle. Optional extra start pulses at
  // relative cycles poke1/poke2 and during the DONE cycle must all be ignored.
  task automatic measure(input string name, input int exp_fixed, input int poke1,
                         input int poke2, input bit poke_done, output int v);
    int  s;
    int  n;
    bit  seen;
    drive_start(1'b1);
    s = cyc;
    @(negedge clk);
    drive_start(1'b0);
    check({name, ":busy_rise"}, 64'(bus_a.busy), 64'd1);
    seen = 1'b0;
    v = 0;
    for (int k = 2; k <= int'(GATE) + 50 && !seen; k++) begin
      @(negedge clk);
      drive_start((k == poke1) || (k == poke2));
      if (bus_a.count_valid) begin
        seen = 1'b1;
        v = cyc;
      end
    end
    drive_start(1'b0);
    check({name, ":valid_seen"}, 64'(seen), 64'd1);
    check({name, ":latency"}, 64'(v - s), 64'(GATE + 1));
    n = model_edges(s);
    check({name, ":count_a"}, 64'(bus_a.count_out), 64'(n));
    check({name, ":valid_b"}, 64'(bus_b.count_valid), 64'd1);
    check({name, ":count_b"}, 64'(bus_b.count_out), 64'((n > MAX_B) ? MAX_B : n));
    check({name, ":busy_done"}, 64'(bus_a.busy), 64'd1);
`ifdef FREQ_METER_OVF_EN
    check({name, ":ovf_a"}, 64'(bus_a.overflow), 64'd0);
    check({name, ":ovf_b"}, 64'(bus_b.overflow), 64'(n > MAX_B));
`endif
    if (exp_fixed >= 0) check({name, ":nominal"}, 64'(bus_a.count_out), 64'(exp_fixed));
    if (poke_done) drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    check({name, ":valid_fall"}, 64'(bus_a.count_valid), 64'd0);
    check({name, ":busy_fall"}, 64'(bus_a.busy), 64'd0);
    check({name, ":count_held"}, 64'(bus_a.count_out), 64'(n));
  endtask

  initial begin
    int v1;
    int v2;
    int strobes;
    drive_start(1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst:busy", 64'(bus_a.busy), 64'd0);
    check("rst:count", 64'(bus_a.count_out), 64'd0);
    check("rst:valid", 64'(bus_a.count_valid), 64'd0);
`ifdef FREQ_METER_OVF_EN
    check("rst:ovf", 64'(bus_b.overflow), 64'd0);
`endif
    reset = 1'b0;
    sig_mode = 2; div_sh = 3;
    idle("pre", 8);

    measure("div8", 125, -1, -1, 1'b0, v1);

    sig_mode = 0; idle("c0_gap", 8);
    measure("const0", 0, -1, -1, 1'b0, v1);
    sig_mode = 1; idle("c1_gap", 8);
    measure("const1", 0, -1, -1, 1'b0, v1);

    sig_mode = 2; div_sh = 3; idle("poke_gap", 8);
    measure("poke", 125, 10, 500, 1'b1, v1);
    idle("after_done_poke", 20);

    // Abort partway through the window.
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    repeat (399) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort:busy", 64'(bus_a.busy), 64'd0);
    check("abort:count_a", 64'(bus_a.count_out), 64'd0);
    check("abort:count_b", 64'(bus_b.count_out), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    strobes = 0;
    for (int k = 0; k < int'(GATE) + 20; k++) begin
      @(negedge clk);
      if (bus_a.count_valid) strobes++;
    end
    check("abort:no_valid", 64'(strobes), 64'd0);
    measure("after_abort", 125, -1, -1, 1'b0, v1);

    sig_mode = 2; div_sh = 2; idle("div4_gap", 8);
    measure("div4_sat", 250, -1, -1, 1'b0, v1);
    sig_mode = 2; div_sh = 5; idle("div32_gap", 8);
    measure("div32", -1, -1, -1, 1'b0, v1);

    // Back-to-back: the second start lands on the first IDLE cycle after DONE.
    sig_mode = 3; rand_pct = int'($urandom_range(20, 80)); idle("b2b_gap", 8);
    measure("b2b_1", -1, -1, -1, 1'b0, v1);
    measure("b2b_2", -1, -1, -1, 1'b0, v2);
    check("b2b:spacing", 64'(v2 - v1), 64'(GATE + 2));

    for (int r = 0; r < 4; r++) begin
      rand_pct = int'($urandom_range(5, 95));
      idle("rand_gap", int'($urandom_range(3, 40)));
      measure("rand", -1, -1, -1, 1'b0, v1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
